fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core. Owns the program counter, drives the word address into the instruction memory, and latches the fetched instruction with its PC+4 into the IF/ID register for the decode/control stage. Handles hazard stalls, taken branch/jump redirects with squash, and the syscall halt that freezes fetch until reset.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit request: hold PC and IF/ID contents.
- redirect  input  1  taken branch or jump resolved in decode.
- redirect_pc  input  32  branch/jump target; bits [1:0] ignored.
- halt  input  1  syscall-exit request from decode.
- imem_addr  output  30  word address to instruction memory, equal to pc[31:2].
- imem_data  input  32  instruction at imem_addr; combinational read, same cycle.
- pc  output  32  current fetch PC.
- id_instr  output  32  IF/ID instruction.
- id_pc_plus4  output  32  IF/ID PC+4 of id_instr.
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- halted  output  1  fetch is frozen after halt.
- fetch_count  output  32  number of instructions latched with id_valid=1 since reset.

## Operation
- State machine, two states:
  - RUN: normal fetching.
  - HALTED: entered when halt=1 in RUN; left only by reset.
- Per-edge priority in RUN: reset > halt > redirect > stall > advance.
  - advance: pc <= pc+4; id_instr <= imem_data; id_pc_plus4 <= pc+4; id_valid <= 1; fetch_count += 1.
  - stall: pc, id_instr, id_pc_plus4, id_valid and fetch_count all hold.
  - redirect: pc <= {redirect_pc[31:2],2'b00}; id_instr <= 0; id_valid <= 0; id_pc_plus4 <= 0; fetch_count holds.
    - The wrong-path instruction is squashed; there is no delay slot.
    - Redirect overrides a simultaneous stall.
  - halt: next state HALTED; pc holds; id_instr <= 0; id_valid <= 0; id_pc_plus4 <= 0; halted <= 1.
    - Halt overrides a simultaneous redirect or stall.
- HALTED: every register holds, and redirect, stall and halt are ignored. imem_addr keeps driving the frozen pc.
- Bubble encoding: id_instr=0 (sll $0,$0,0).
- Arithmetic: pc+4 is 32-bit modulo 2^32, so 32'hFFFF_FFFC advances to 0. fetch_count wraps from 32'hFFFF_FFFF to 0.
- imem_addr = pc[31:2] at all times, combinationally.

## Timing
- Reset values, visible after the first clk edge with reset=1: pc=RESET_PC, id_instr=0, id_pc_plus4=0, id_valid=0, halted=0, fetch_count=0, state RUN.
- Reset asserted mid-operation, including in HALTED, reinitialises everything at that edge regardless of other inputs.
- Fetch-to-decode latency is 1 cycle. The instruction at pc in cycle N appears on id_instr in cycle N+1.
- Redirect penalty is 1 bubble:
  - redirect sampled at edge N;
  - target instruction appears on id_instr after edge N+1.
- Stall is level-sensitive. Each stalled cycle repeats the same imem_addr, and outputs are unchanged.
- halted rises at the edge that samples halt. imem_addr is constant from that edge on.

## Test plan
- Reset/sequential: RESET_PC=0, imem[0..2]=A,B,C; release reset.
  - After edges 1, 2, 3: id_instr=A,B,C; id_pc_plus4=4,8,12; id_valid=1; fetch_count=1,2,3; pc=12.
- Stall: at pc=8 hold stall=1 for 2 cycles.
  - pc stays 8; id_instr stays B; fetch_count stays 2.
  - After release: id_instr=C next edge.
- Redirect with squash: redirect=1, redirect_pc=32'h0000_0043 while stall=1.
  - Next edge: pc=32'h40, id_valid=0, id_instr=0.
  - Following edge: id_instr=imem[0x40>>2], id_pc_plus4=32'h44.
- Halt priority: halt=1 and redirect=1 in the same cycle at pc=16.
  - halted=1; pc stays 16 for 10 further cycles, with toggling redirect/stall ignored; id_valid=0.
- Reset mid-halt and wrap: reset during HALTED, then reset with RESET_PC=32'hFFFF_FFFC.
  - After the HALTED reset: all reset values are restored.
  - After the RESET_PC=32'hFFFF_FFFC reset and one advance: pc=0, id_pc_plus4=0, id_valid=1.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- MIPS instruction fetch plus IF/ID pipeline register.
//
// Holds the program counter, presents the word address to the instruction
// memory, and latches the fetched word and its PC+4 into IF/ID. Supports
// hazard stalls, taken branch/jump redirects (wrong-path fetch squashed,
// no delay slot) and a syscall halt that freezes fetch until reset.
//
// Ports:
//   clk, reset           core clock, synchronous active-high reset
//   stall                hold PC and IF/ID
//   redirect/redirect_pc taken branch/jump and its target (bits [1:0] dropped)
//   halt                 syscall exit; freezes fetch until reset
//   imem_addr/imem_data  word address out, instruction in (same cycle)
//   pc                   current fetch PC
//   id_instr/id_pc_plus4/id_valid  IF/ID register
//   halted               fetch frozen
//   fetch_count          valid instructions latched since reset (wraps)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc4, w_pc4_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;  // modulo 2^32

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc4   <= w_pc4_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Priority in RUN: halt > redirect > stall > advance. HALTED holds all.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (halt) begin
          w_state_nxt = S_HALTED;
          w_instr_nxt = '0;
          w_pc4_nxt   = '0;
          w_valid_nxt = 1'b0;
        end else if (redirect) begin
          // Squash the wrong-path word currently being fetched.
          w_pc_nxt    = {redirect_pc[31:2], 2'b00};
          w_instr_nxt = '0;
          w_pc4_nxt   = '0;
          w_valid_nxt = 1'b0;
        end else if (!stall) begin
          w_pc_nxt    = w_pc_plus4;
          w_instr_nxt = imem_data;
          w_pc4_nxt   = w_pc_plus4;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + 32'd1;
        end
      end
      default: ;
    endcase
  end

  assign imem_addr   = r_pc[31:2];
  assign pc          = r_pc;
  assign id_instr    = r_instr;
  assign id_pc_plus4 = r_pc4;
  assign id_valid    = r_valid;
  assign halted      = (r_state == S_HALTED);
  assign fetch_count = r_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, halt;
  logic [31:0] redirect_pc;
  logic [29:0] a0, a1;
  logic [31:0] d0, d1;
  logic [31:0] pc0, in0, p40, cnt0, pc1, in1, p41, cnt1;
  logic        v0, h0, v1, h1;

  logic [31:0] mem [0:63];
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc, instr, pc4, cnt;
    logic        v, h;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  assign d0 = mem[a0[5:0]];
  assign d1 = mem[a1[5:0]];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .imem_addr(a0), .imem_data(d0),
    .pc(pc0), .id_instr(in0), .id_pc_plus4(p40), .id_valid(v0),
    .halted(h0), .fetch_count(cnt0));

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .imem_addr(a1), .imem_data(d1),
    .pc(pc1), .id_instr(in1), .id_pc_plus4(p41), .id_valid(v1),
    .halted(h1), .fetch_count(cnt1));

  task automatic cmp32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push0(input logic [31:0] p, input logic [31:0] i, input logic [31:0] p4,
                       input logic v, input logic h, input logic [31:0] c);
    exp_t e;
    e.pc = p; e.instr = i; e.pc4 = p4; e.v = v; e.h = h; e.cnt = c;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [31:0] p, input logic [31:0] i, input logic [31:0] p4,
                       input logic v, input logic h, input logic [31:0] c);
    exp_t e;
    e.pc = p; e.instr = i; e.pc4 = p4; e.v = v; e.h = h; e.cnt = c;
    q1.push_back(e);
  endtask

  task automatic chk0(input string tag);
    exp_t e;
    if (q0.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL %s: scoreboard empty, got pc %h expected an entry", tag, pc0);
    end else begin
      e = q0.pop_front();
      cmp32({tag, " pc"}, pc0, e.pc);
      cmp32({tag, " imem_addr"}, {2'b00, a0}, {2'b00, e.pc[31:2]});
      cmp32({tag, " id_instr"}, in0, e.instr);
      cmp32({tag, " id_pc_plus4"}, p40, e.pc4);
      cmp32({tag, " id_valid"}, {31'd0, v0}, {31'd0, e.v});
      cmp32({tag, " halted"}, {31'd0, h0}, {31'd0, e.h});
      cmp32({tag, " fetch_count"}, cnt0, e.cnt);
    end
  endtask

  task automatic chk1(input string tag);
    exp_t e;
    if (q1.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL %s: scoreboard empty, got pc %h expected an entry", tag, pc1);
    end else begin
      e = q1.pop_front();
      cmp32({tag, " pc"}, pc1, e.pc);
      cmp32({tag, " id_instr"}, in1, e.instr);
      cmp32({tag, " id_pc_plus4"}, p41, e.pc4);
      cmp32({tag, " id_valid"}, {31'd0, v1}, {31'd0, e.v});
      cmp32({tag, " halted"}, {31'd0, h1}, {31'd0, e.h});
      cmp32({tag, " fetch_count"}, cnt1, e.cnt);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;

    // Reset state
    push0(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    push1(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    edge_wait(); chk0("reset"); chk1("reset1");

    // Sequential fetch A, B
    reset = 1'b0;
    push0(32'd4, mem[0], 32'd4, 1'b1, 1'b0, 32'd1);
    edge_wait(); chk0("seq A");
    push0(32'd8, mem[1], 32'd8, 1'b1, 1'b0, 32'd2);
    edge_wait(); chk0("seq B");

    // Stall two cycles at pc=8
    stall = 1'b1;
    push0(32'd8, mem[1], 32'd8, 1'b1, 1'b0, 32'd2);
    edge_wait(); chk0("stall 1");
    push0(32'd8, mem[1], 32'd8, 1'b1, 1'b0, 32'd2);
    edge_wait(); chk0("stall 2");
    stall = 1'b0;
    push0(32'd12, mem[2], 32'd12, 1'b1, 1'b0, 32'd3);
    edge_wait(); chk0("seq C");

    // Redirect overrides stall; low bits of target dropped
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0043;
    push0(32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'd3);
    edge_wait(); chk0("redirect squash");
    stall = 1'b0; redirect = 1'b0;
    push0(32'h44, mem[16], 32'h44, 1'b1, 1'b0, 32'd4);
    edge_wait(); chk0("redirect target");

    // Move to pc=16, then halt with a simultaneous redirect
    redirect = 1'b1; redirect_pc = 32'h0000_0010;
    push0(32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 32'd4);
    edge_wait(); chk0("redirect 16");
    halt = 1'b1; redirect_pc = 32'h0000_0080;
    push0(32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 32'd4);
    edge_wait(); chk0("halt");
    for (int k = 0; k < 10; k++) begin
      halt = k[0]; redirect = ~k[0]; stall = k[1];
      push0(32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 32'd4);
      edge_wait(); chk0($sformatf("halted %0d", k));
    end

    // Reset during HALTED with other inputs active
    reset = 1'b1; redirect = 1'b1; halt = 1'b1; stall = 1'b1;
    push0(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    push1(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    edge_wait(); chk0("reset mid-halt"); chk1("reset1 again");
    reset = 1'b0; redirect = 1'b0; halt = 1'b0; stall = 1'b0;
    push0(32'd4, mem[0], 32'd4, 1'b1, 1'b0, 32'd1);
    push1(32'h0, mem[63], 32'h0, 1'b1, 1'b0, 32'd1);
    edge_wait(); chk0("post-reset advance"); chk1("pc wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
